// File: rtl/gerador_modo.sv
// Time-of-day and day/night mode source: 1 Hz prescaler, 24 h clock settable by two
// debounced push-buttons, and a registered mode output with a debounced manual override.
module gerador_modo #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int DEBOUNCE_CYC = 500_000,
  parameter int NOITE_INI    = 22,
  parameter int NOITE_FIM    = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_hora,
  input  logic       btn_min,
  input  logic       chave_manual,
  input  logic       modo_manual,
  output logic       modo,
  output logic [4:0] hora,
  output logic [5:0] minuto,
  output logic       seg_tick
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYC);

  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);
  localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE_CYC - 1);
  localparam logic [4:0]    H_INI   = 5'(NOITE_INI);
  localparam logic [4:0]    H_FIM   = 5'(NOITE_FIM);

  // Bit positions inside the synchronized input vector; the first three are debounced.
  localparam int CH_HORA   = 0;
  localparam int CH_MIN    = 1;
  localparam int CH_CHAVE  = 2;
  localparam int CH_MANUAL = 3;

  typedef struct packed {
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
  } hms_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizers for every raw input
  // ---------------------------------------------------------------------------
  logic [3:0] raw;
  logic [3:0] sync_a;
  logic [3:0] sync_b;

  assign raw = {modo_manual, chave_manual, btn_min, btn_hora};

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // ---------------------------------------------------------------------------
  // Debouncers: level follows the synchronized input after DEBOUNCE_CYC
  // consecutive differing cycles
  // ---------------------------------------------------------------------------
  logic [2:0]    db_level;
  logic [2:0]    db_done;
  logic [DW-1:0] db_cnt [3];
  logic          inc_hora;
  logic          inc_min;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      db_done[i] = (sync_b[i] != db_level[i]) && (db_cnt[i] == DB_MAX);
    end
  end

  // Increments fire on the same edge that raises the debounced level.
  assign inc_hora = db_done[CH_HORA] & sync_b[CH_HORA];
  assign inc_min  = db_done[CH_MIN]  & sync_b[CH_MIN];

  // NOTE: the counter array is tiny and must start at zero, so it is reset element by element.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_level <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if ((sync_b[i] == db_level[i]) || db_done[i]) db_cnt[i] <= '0;
        else                                          db_cnt[i] <= db_cnt[i] + 1'b1;
        if (db_done[i]) db_level[i] <= sync_b[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler and one-second pulse
  // ---------------------------------------------------------------------------
  logic [PW-1:0] presc;
  logic          tick_now;

  assign tick_now = (presc == PRE_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc    <= '0;
      seg_tick <= 1'b0;
    end else begin
      presc    <= tick_now ? '0 : presc + 1'b1;
      seg_tick <= tick_now;
    end
  end

  // ---------------------------------------------------------------------------
  // Time of day: button adjusts take priority and swallow a coincident tick
  // ---------------------------------------------------------------------------
  hms_t t_q;
  hms_t t_d;

  // NOTE: t_d gets a full default first so no path through this block can infer a latch.
  always_comb begin
    t_d = t_q;
    if (inc_hora || inc_min) begin
      if (inc_hora) t_d.h = (t_q.h == 5'd23) ? 5'd0 : t_q.h + 5'd1;
      if (inc_min) begin
        t_d.m = (t_q.m == 6'd59) ? 6'd0 : t_q.m + 6'd1;
        t_d.s = 6'd0;
      end
    end else if (tick_now) begin
      if (t_q.s == 6'd59) begin
        t_d.s = 6'd0;
        if (t_q.m == 6'd59) begin
          t_d.m = 6'd0;
          t_d.h = (t_q.h == 5'd23) ? 5'd0 : t_q.h + 5'd1;
        end else begin
          t_d.m = t_q.m + 6'd1;
        end
      end else begin
        t_d.s = t_q.s + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) t_q <= '0;
    else      t_q <= t_d;
  end

  assign hora   = t_q.h;
  assign minuto = t_q.m;

  // ---------------------------------------------------------------------------
  // Mode register: override forces the synchronized manual level, otherwise
  // night is derived from the registered hour
  // ---------------------------------------------------------------------------
  logic noite;

  assign noite = (t_q.h >= H_INI) || (t_q.h < H_FIM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    modo <= 1'b1;
    else if (db_level[CH_CHAVE]) modo <= sync_b[CH_MANUAL];
    else                         modo <= noite;
  end

endmodule

// File: tb/tb_gerador_modo.sv
// Self-checking bench for gerador_modo: table-driven debounce vectors, directed corner
// sequences, and randomized stimulus compared every cycle against a seconds-of-day model.
module tb_gerador_modo;

  localparam int CLK_HZ = 4;
  localparam int DC     = 3;
  localparam int NI     = 22;
  localparam int NF     = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_hora = 1'b0;
  logic       btn_min = 1'b0;
  logic       chave_manual = 1'b0;
  logic       modo_manual = 1'b0;
  logic       modo;
  logic [4:0] hora;
  logic [5:0] minuto;
  logic       seg_tick;

  always #5 clk = ~clk;

  gerador_modo #(
    .CLK_HZ(CLK_HZ), .DEBOUNCE_CYC(DC), .NOITE_INI(NI), .NOITE_FIM(NF)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_hora(btn_hora), .btn_min(btn_min),
    .chave_manual(chave_manual), .modo_manual(modo_manual),
    .modo(modo), .hora(hora), .minuto(minuto), .seg_tick(seg_tick)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: time kept as seconds of day; debounced levels decided from
  // a history of raw samples (newest first)
  // ---------------------------------------------------------------------------
  int         e_cnt;
  int         tod;
  logic [3:0] hist[$];
  bit         lvl [3];
  bit         m_tick;
  bit         m_modo;

  function automatic int m_h(); return tod / 3600;       endfunction
  function automatic int m_m(); return (tod / 60) % 60;  endfunction
  function automatic int m_s(); return tod % 60;         endfunction

  function automatic bit night(input int h);
    return (h >= NI) || (h < NF);
  endfunction

  function automatic bit raw_ago(input int ch, input int k);
    logic [3:0] v;
    v = 4'b0000;
    if (k < hist.size()) v = hist[k];
    return v[ch];
  endfunction

  task automatic model_reset();
    hist.delete();
    e_cnt  = 0;
    tod    = 0;
    lvl    = '{1'b0, 1'b0, 1'b0};
    m_tick = 1'b0;
    m_modo = 1'b1;
  endtask

  task automatic model_edge();
    bit flip [3];
    bit tick;
    bit rise_h;
    bit rise_m;
    bit new_modo;
    int h, m, s;
    hist.push_front({modo_manual, chave_manual, btn_min, btn_hora});
    if (hist.size() > 8) void'(hist.pop_back());
    e_cnt++;
    // A level flips once the synchronized view (2 samples old) has disagreed for DC samples.
    for (int ch = 0; ch < 3; ch++) begin
      flip[ch] = 1'b1;
      for (int k = 2; k <= DC + 1; k++) if (raw_ago(ch, k) == lvl[ch]) flip[ch] = 1'b0;
    end
    rise_h   = flip[0] && !lvl[0];
    rise_m   = flip[1] && !lvl[1];
    new_modo = lvl[2] ? raw_ago(3, 2) : night(m_h());
    tick     = (e_cnt % CLK_HZ) == 0;
    h = m_h(); m = m_m(); s = m_s();
    if (rise_h || rise_m) begin
      if (rise_h) h = (h + 1) % 24;
      if (rise_m) begin
        m = (m + 1) % 60;
        s = 0;
      end
      tod = h * 3600 + m * 60 + s;
    end else if (tick) begin
      tod = (tod + 1) % 86400;
    end
    m_tick = tick;
    m_modo = new_modo;
    for (int ch = 0; ch < 3; ch++) lvl[ch] = lvl[ch] ^ flip[ch];
  endtask

  // One clock: advance the model on the edge, compare all outputs 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check($sformatf("hora@%0d", e_cnt), int'(hora), m_h());
    check($sformatf("minuto@%0d", e_cnt), int'(minuto), m_m());
    check($sformatf("seg_tick@%0d", e_cnt), int'(seg_tick), int'(m_tick));
    check($sformatf("modo@%0d", e_cnt), int'(modo), int'(m_modo));
  endtask

  task automatic press(input bit is_min);
    if (is_min) btn_min = 1'b1; else btn_hora = 1'b1;
    repeat (4) cycle();
    btn_min  = 1'b0;
    btn_hora = 1'b0;
    repeat (4) cycle();
  endtask

  // Drive the clock to h:m (and, when s >= 0, wait for the tick that reaches second s).
  task automatic preset(input int h, input int m, input int s);
    int n;
    n = 0;
    while (m_m() != m && n < 70) begin press(1'b1); n++; end
    n = 0;
    while (m_h() != h && n < 30) begin press(1'b0); n++; end
    if (s >= 0) begin
      n = 0;
      while (!(m_s() == s && m_tick) && n < 300) begin cycle(); n++; end
      check("preset_seg_wait", int'(n < 300), 1);
    end
    check("preset_hora", int'(hora), h);
    check("preset_minuto", int'(minuto), m);
  endtask

  typedef struct {
    logic [15:0] pat;
    int          inc;
    string       name;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0, n, ticks;

    // Raw btn_hora waveforms (bit 0 first) and the number of accepted presses.
    vecs[0] = '{16'h5555, 0, "bounce_1cyc"};
    vecs[1] = '{16'h3333, 0, "bounce_2cyc"};
    vecs[2] = '{16'h0C63, 0, "bounce_pairs"};
    vecs[3] = '{16'h0000, 0, "idle"};
    vecs[4] = '{16'h0007, 1, "hold_3"};
    vecs[5] = '{16'h001F, 1, "hold_5"};
    vecs[6] = '{16'h0077, 1, "glitch_low"};
    vecs[7] = '{16'h0F0F, 2, "two_presses"};
    vecs[8] = '{16'h0E07, 2, "two_short_presses"};
    vecs[9] = '{16'hFFFF, 1, "hold_long"};

    // Reset state
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_hora", int'(hora), 0);
    check("rst_minuto", int'(minuto), 0);
    check("rst_seg_tick", int'(seg_tick), 0);
    check("rst_modo", int'(modo), 1);
    rst = 1'b1;

    // First seconds: pulse on edges 4, 8, 12
    for (int i = 1; i <= 12; i++) begin
      cycle();
      check($sformatf("tick_period_%0d", i), int'(seg_tick), int'((i % 4) == 0));
    end

    // Debounce table
    for (int v = 0; v < 10; v++) begin
      logic [15:0] p;
      p  = vecs[v].pat;
      h0 = int'(hora);
      for (int b = 0; b < 16; b++) begin
        btn_hora = p[b];
        cycle();
      end
      btn_hora = 1'b0;
      repeat (8) cycle();
      check(vecs[v].name, (int'(hora) - h0 + 24) % 24, vecs[v].inc);
    end

    // Held 5 cycles: exactly one increment, on the fifth edge
    h0 = int'(hora);
    btn_hora = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cycle();
      if (i < 5) check("hold5_wait", int'(hora), h0);
      else       check("hold5_inc", int'(hora), (h0 + 1) % 24);
    end
    btn_hora = 1'b0;
    repeat (8) cycle();
    check("hold5_once", int'(hora), (h0 + 1) % 24);

    // Midnight rollover
    preset(23, 59, 58);
    n = 0;
    while (tod != 0 && n < 12) begin cycle(); n++; end
    check("wrap_hora", int'(hora), 0);
    check("wrap_minuto", int'(minuto), 0);
    check("wrap_tick", int'(seg_tick), 1);

    // Night -> day at 06:00
    preset(5, 59, 59);
    n = 0;
    while (m_h() != 6 && n < 8) begin cycle(); n++; end
    check("dia_hora", int'(hora), 6);
    check("dia_modo_hold", int'(modo), 1);
    cycle();
    check("dia_modo", int'(modo), 0);

    // Day -> night at 22:00
    preset(21, 59, 59);
    n = 0;
    while (m_h() != 22 && n < 8) begin cycle(); n++; end
    check("noite_hora", int'(hora), 22);
    check("noite_modo_hold", int'(modo), 0);
    cycle();
    check("noite_modo", int'(modo), 1);

    // Minute adjust at 03:59:30, aligned so the increment lands on a tick edge
    preset(3, 59, 30);
    n = 0;
    while ((e_cnt % 4) != 3 && n < 4) begin cycle(); n++; end
    btn_min = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cycle();
      if (i < 5) check("min_wait", int'(minuto), 59);
    end
    check("min_minuto", int'(minuto), 0);
    check("min_hora", int'(hora), 3);
    check("min_tick_coincident", int'(seg_tick), 1);
    btn_min = 1'b0;
    ticks = 0;
    n = 0;
    while (minuto == 6'd0 && n < 300) begin
      cycle();
      if (seg_tick) ticks++;
      n++;
    end
    check("min_seg_cleared", ticks, 60);
    check("min_no_hour_carry", int'(hora), 3);

    // Manual override at noon
    preset(12, 0, -1);
    modo_manual  = 1'b1;
    chave_manual = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      cycle();
      if (i == 5) check("ovr_pre", int'(modo), 0);
    end
    check("ovr_on", int'(modo), 1);
    chave_manual = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      cycle();
      if (i == 5) check("ovr_hold", int'(modo), 1);
    end
    check("ovr_off", int'(modo), 0);

    // Randomized stimulus against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(3) == 0) btn_hora     = ~btn_hora;
      if ($urandom_range(3) == 0) btn_min      = ~btn_min;
      if ($urandom_range(7) == 0) chave_manual = ~chave_manual;
      if ($urandom_range(5) == 0) modo_manual  = ~modo_manual;
      cycle();
    end
    btn_hora = 1'b0; btn_min = 1'b0; chave_manual = 1'b0; modo_manual = 1'b0;
    repeat (8) cycle();

    // Reset two cycles into a debounce count: press is lost
    btn_hora = 1'b1;
    repeat (4) cycle();
    rst = 1'b0;
    #1;
    check("mid_rst_hora", int'(hora), 0);
    check("mid_rst_minuto", int'(minuto), 0);
    check("mid_rst_seg_tick", int'(seg_tick), 0);
    check("mid_rst_modo", int'(modo), 1);
    model_reset();
    btn_hora = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (24) cycle();
    check("mid_rst_no_press", int'(hora), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gerador_modo.md
# gerador_modo

Time-of-day and mode source for the intersection controller. It divides the system clock into a 1 Hz tick and keeps a 24-hour clock (hora:minuto:segundo) that can be set with two push-buttons. From that clock it drives `modo` (0 = diurno, 1 = noturno), which the traffic-light FSM consumes directly. A debounced manual switch can override the time-based mode.

## Interface
- `CLK_HZ`, default 50_000_000: clock cycles per second; prescaler terminal count is `CLK_HZ-1`.
- `DEBOUNCE_CYC`, default 500_000: consecutive stable cycles required by each debouncer; must be ≥ 2.
- `NOITE_INI`, default 22: first night hour, inclusive.
- `NOITE_FIM`, default 6: first day hour; night is hours `NOITE_FIM-1` and earlier.
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset, asynchronous and active-low.
- `btn_hora`, in, 1: raw push-button; each press adds one hour.
- `btn_min`, in, 1: raw push-button; each press adds one minute.
- `chave_manual`, in, 1: raw switch; when its debounced level is 1, the manual override is active.
- `modo_manual`, in, 1: mode forced while the override is active; sampled through the synchronizer, not debounced.
- `modo`, out, 1: mode to the traffic FSM; 0 = diurno, 1 = noturno.
- `hora`, out, 5: hour, 0–23.
- `minuto`, out, 6: minute, 0–59.
- `seg_tick`, out, 1: one-cycle pulse once per second.

## Operation
- **Reset** (`rst`=0, asynchronous):
  - prescaler = 0, segundo = 0, `minuto` = 0, `hora` = 0;
  - synchronizers = 0, debounced levels = 0, debounce counters = 0;
  - `seg_tick` = 0, `modo` = 1 (00:00 is night).
- **Input synchronization:** every raw input (`btn_hora`, `btn_min`, `chave_manual`, `modo_manual`) passes through a 2-flop synchronizer before any use.
- **Debouncer** (one each for `btn_hora`, `btn_min`, `chave_manual`):
  - A counter runs while the synchronized value differs from the debounced level.
  - Any cycle where they are equal clears the counter.
  - When the counter reaches `DEBOUNCE_CYC-1` with the values still differing, the debounced level takes the synchronized value and the counter clears.
- **Button press:** the clock edge that moves a button's debounced level 0→1 also applies its increment. Release (1→0) has no effect.
- **Prescaler:**
  - Counts 0..`CLK_HZ-1` and wraps.
  - `seg_tick` is registered and equals 1 in the cycle after the prescaler holds `CLK_HZ-1`.
- **Time advance on tick:**
  - segundo+1; 59→0 carries into `minuto`.
  - `minuto` 59→0 carries into `hora`.
  - `hora` 23→0, with no further carry.
- **Adjust, hour:** `hora`+1, wrapping 23→0. `minuto` and segundo are unchanged.
- **Adjust, minute:** `minuto`+1, wrapping 59→0 with no carry into `hora`. Segundo is cleared to 0.
- **Priority:**
  - In any cycle where an adjust increment is applied, that cycle's tick-driven advance is dropped entirely.
  - The prescaler and `seg_tick` themselves are unaffected.
  - If both buttons' increments fall on the same edge, both are applied.
- **Mode:** `modo` is a register updated every cycle.
  - Override active: `modo` ← synchronized `modo_manual`.
  - Otherwise: `modo` ← 1 if `hora` ≥ `NOITE_INI` or `hora` < `NOITE_FIM`, else 0.
  - The comparison uses the registered `hora`.

## Timing
- Raw button edge held stable to increment applied: 2 (synchronizer) + `DEBOUNCE_CYC` cycles.
- Change of `hora` to `modo` update: 1 cycle.
- Override asserted to `modo` = `modo_manual`: 1 cycle after the debounced level rises.
- Override released: `modo` returns to the time-derived value 1 cycle after the debounced level falls.
- `seg_tick` period is exactly `CLK_HZ` cycles. The first pulse comes `CLK_HZ` cycles after reset release.
- `hora`/`minuto` change on the same edge on which `seg_tick` is first seen high.
- Reset asserted mid-debounce or mid-count: everything returns immediately to reset values, and a pending press is lost.
- Bounces shorter than `DEBOUNCE_CYC` cycles never change a debounced level.

## Test plan
Bench parameters for all scenarios: `CLK_HZ`=4, `DEBOUNCE_CYC`=3, `NOITE_INI`=22, `NOITE_FIM`=6.

- **Reset and rollover:** reset, then run 86_400×4 cycles.
  - Right after reset: `modo`=1, `hora`=0, `minuto`=0, `seg_tick`=0.
  - `seg_tick` pulses every 4 cycles.
  - 23:59:59 wraps to 00:00:00.
- **Day/night switching:** preset the clock to 05:59:59 via the buttons, then wait for one tick.
  - `hora`=6, then `modo`=0 one cycle later.
  - Preset to 21:59:59 and wait for one tick: `hora`=22, then `modo`=1 one cycle later.
- **Debounce:**
  - `btn_hora` toggling with 1–2 cycle pulses: no change to `hora`.
  - `btn_hora` held 5 cycles: `hora` +1 exactly once, 5 cycles after the edge.
- **Minute adjust:** at `minuto`=59, `hora`=3, segundo=30, press `btn_min`.
  - Result: `minuto`=0, `hora`=3, segundo=0.
  - A tick landing on the adjust edge is dropped.
- **Manual override:** at `hora`=12, set `modo_manual`=1 and `chave_manual`=1.
  - `modo`=1 one cycle after the debounced switch rises.
  - Release the switch: `modo`=0 one cycle after the debounced level falls.
- **Reset mid-press:** assert `rst` 2 cycles into a debounce count.
  - All outputs return to reset values immediately.
  - No increment occurs after release.
